data_register_reader: RTL and testbench
=======================================

// Module: data_register_reader
// PURPOSE
//  Block-read engine for the data register file. Drives the file's read
//  address (address_2 side) and samples the combinational read data.
//  Streams word_count consecutive registers out over a valid/ready port
//  toward the transmit path. It is the reading end of the file; the
//  write port is unaffected.
// PARAMETERS
//  ADDR_WIDTH_RF  4   register file address width; 2**ADDR_WIDTH_RF registers
//  DATA_WIDTH     16  register word width
// PORTS
//  clk            in   1                  single clock, rising edge
//  reset_n        in   1                  asynchronous, active-low reset
//  start          in   1                  begin block read; sampled in IDLE only
//  start_address  in   ADDR_WIDTH_RF      first register to read
//  word_count     in   ADDR_WIDTH_RF+1    words to send, 0..2**ADDR_WIDTH_RF
//  rf_address     out  ADDR_WIDTH_RF      to register file read address
//  rf_read_data   in   DATA_WIDTH         from register file read_data (comb.)
//  tx_data        out  DATA_WIDTH         registered output word
//  tx_valid       out  1                  tx_data valid
//  tx_ready       in   1                  downstream accepts when high with tx_valid
//  busy           out  1                  high in any state other than IDLE
//  done           out  1                  one-cycle pulse at end of block
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; rf_address, tx_data, tx_valid,
//   busy, done, address counter and remaining counter all 0.
//  FSM states: IDLE, FETCH, SEND, DONE.
//  - IDLE with start=1: latch start_address->addr and word_count->remaining.
//    If word_count==0, go to DONE; otherwise go to FETCH.
//  - FETCH (1 cycle): rf_address=addr. On clock edge, tx_data<=rf_read_data,
//    tx_valid<=1, then go to SEND.
//  - SEND: tx_data and tx_valid are held stable while tx_ready=0.
//    On tx_valid&&tx_ready: tx_valid<=0 and remaining<=remaining-1.
//    If remaining==1, go to DONE. Otherwise addr<=addr+1 and go to FETCH.
//  - DONE: done=1 for exactly one cycle, then return to IDLE.
//  Latency: start to first tx_valid is 2 cycles. Peak rate is 1 word per
//   2 cycles (FETCH/SEND alternate).
//  rf_address is driven as addr in all states; it is 0 after reset.
//  Wrap-around: addr increments modulo 2**ADDR_WIDTH_RF. A 4-word read from
//   address 14 with ADDR_WIDTH_RF=4 reads 14, 15, 0, 1.
//  Full-file read: word_count = 2**ADDR_WIDTH_RF sends every register once.
//  start while busy is ignored; the inputs are not re-latched.
//  Write collision: if the file is written at addr in the FETCH cycle, the
//   reader captures the pre-write value. The file read is combinational and
//   the write commits on the same edge.
//  Reset mid-block: reset aborts immediately to IDLE. No done pulse is
//   emitted and the partial block is discarded.
//  done and busy are registered; busy falls in the same cycle done rises.
// CONFIGURATION
//  DATA_REGISTER_READER_PARITY_EN defined:
//   - adds output tx_parity (1 bit) = ^tx_data (even parity).
//   - tx_parity is registered alongside tx_data and reset to 0.
//  DATA_REGISTER_READER_PARITY_EN undefined:
//   - the tx_parity port and its logic are absent; all else is identical.
// TESTING
//  1. Preload regs 3..5 = A1,B2,C3; start, addr=3, count=3, tx_ready=1
//     -> A1,B2,C3 sent, 1 word per 2 cycles; done pulses once; busy then 0.
//  2. addr=14, count=4, ADDR_WIDTH_RF=4 -> words from regs 14,15,0,1 in order.
//  3. count=0 -> no tx_valid; done pulses 2 cycles after start.
//  4. tx_ready held 0 for 5 cycles during SEND -> tx_valid stays 1 and
//     tx_data is stable; the word is sent once when tx_ready rises.
//     A start pulse during busy has no effect.
//  5. Assert reset_n=0 after word 1 of 4 -> outputs go to 0 immediately;
//     no done pulse; a new start then works normally.
//  6. With PARITY_EN: reg=16'h0007 -> tx_parity=1; reg=16'h0003 -> tx_parity=0.

Source files
------------

// File: rtl/data_register_reader.sv
// Block-read engine: streams word_count registers from start_address out over valid/ready (option: DATA_REGISTER_READER_PARITY_EN).
// Latency: first tx_valid 2 cycles after start; at most one word every 2 cycles.
// Backpressure: tx_data/tx_valid hold while tx_ready=0; start is ignored while busy.
module data_register_reader #(
   parameter int ADDR_WIDTH_RF = 4,
   parameter int DATA_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDR_WIDTH_RF-1:0] start_address,
   input  logic [ADDR_WIDTH_RF:0]   word_count,
   output logic [ADDR_WIDTH_RF-1:0] rf_address,
   input  logic [DATA_WIDTH-1:0]    rf_read_data,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
`ifdef DATA_REGISTER_READER_PARITY_EN
   output logic                     tx_parity,
`endif
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH_RF:0] LAST_WORD = 1;

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH_RF-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH_RF:0]   rem_q, rem_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = start_address;
               rem_d   = word_count;
               state_d = (word_count == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            // Read is combinational, so a same-edge write is not yet visible here.
            data_d  = rf_read_data;
            valid_d = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (valid_q && tx_ready) begin
               valid_d = 1'b0;
               rem_d   = rem_q - 1'b1;
               if (rem_q == LAST_WORD) begin
                  state_d = DONE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // busy drops on the same edge that raises the single-cycle done pulse.
   assign busy_d = (state_d != IDLE);
   assign done_d = (state_q == DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef DATA_REGISTER_READER_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= ^data_d;
      end
   end

   assign tx_parity = parity_q;
`endif

   assign rf_address = addr_q;
   assign tx_data    = data_q;
   assign tx_valid   = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_data_register_reader.sv
// Bench for data_register_reader: randomized block reads against a register-file array model.
module tb_data_register_reader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [3:0]  start_address;
   logic [4:0]  word_count;
   logic [3:0]  rf_address;
   logic [15:0] rf_read_data;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;
`ifdef DATA_REGISTER_READER_PARITY_EN
   logic        tx_parity;
`endif

   logic [15:0] mem [16];
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;

   int tests_run = 0;
   int tests_failed = 0;

   data_register_reader #(.ADDR_WIDTH_RF(4), .DATA_WIDTH(16)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .start_address (start_address),
      .word_count    (word_count),
      .rf_address    (rf_address),
      .rf_read_data  (rf_read_data),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
`ifdef DATA_REGISTER_READER_PARITY_EN
      .tx_parity     (tx_parity),
`endif
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: combinational read, write commits on the clock edge.
   assign rf_read_data = mem[rf_address];
   always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // rdy_mode: 0 always ready, 1 random ready, 2 ready low for cycles 2..6.
   task automatic run_block(input int sa, input int cnt, input int rdy_mode,
                            input bit poke, input bit collide);
      logic [15:0] exp_q[$];
      int cyc, first_valid, done_cyc;
      logic prev_v, prev_r;
      logic [15:0] prev_d, w;
      for (int i = 0; i < cnt; i++) exp_q.push_back(mem[(sa + i) % 16]);
      @(negedge clk);
      start = 1'b1; start_address = 4'(sa); word_count = 5'(cnt); tx_ready = 1'b1;
      cyc = 0; first_valid = -1; done_cyc = -1;
      prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
      while (cyc < 300 && done_cyc < 0) begin
         @(negedge clk);
         cyc++;
         start = (poke && cyc == 3) ? 1'b1 : 1'b0;
         start_address = 4'($urandom_range(0, 15));
         word_count = 5'($urandom_range(1, 16));
         wr_en = (collide && cyc == 1);
         wr_addr = 4'(sa);
         wr_data = ~mem[sa];
         case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = (cyc >= 2 && cyc <= 6) ? 1'b0 : 1'b1;
         endcase
         if (prev_v && !prev_r) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_d));
         end
         prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
         if (tx_valid && first_valid < 0) first_valid = cyc;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) chk("extra_word", 32'(tx_data), 32'hFFFF_FFFF);
            else begin
               w = exp_q.pop_front();
               chk("word", 32'(tx_data), 32'(w));
`ifdef DATA_REGISTER_READER_PARITY_EN
               chk("parity", 32'(tx_parity), 32'(^w));
`endif
            end
         end
         if (done) begin
            done_cyc = cyc;
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
      start = 1'b0; wr_en = 1'b0; tx_ready = 1'b1;
      chk("done_seen", 32'(done_cyc >= 0), 32'd1);
      chk("words_left", 32'(exp_q.size()), 32'd0);
      if (cnt > 0) chk("first_valid_lat", 32'(first_valid), 32'd2);
      else         chk("no_valid", 32'(first_valid), 32'hFFFF_FFFF);
      if (rdy_mode == 0) chk("done_lat", 32'(done_cyc), 32'(cnt == 0 ? 2 : 2 * cnt + 2));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(tx_valid), 32'd0);
   endtask

   initial begin
      int c;
      reset_n = 1'b0; start = 1'b0; start_address = '0; word_count = '0;
      tx_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      mem[3] = 16'h00A1; mem[4] = 16'h00B2; mem[5] = 16'h00C3;
      repeat (2) @(negedge clk);
      chk("rst_rf_address", 32'(rf_address), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
`ifdef DATA_REGISTER_READER_PARITY_EN
      chk("rst_parity", 32'(tx_parity), 32'd0);
`endif
      reset_n = 1'b1;
      @(negedge clk);

      run_block(3, 3, 0, 1'b0, 1'b0);
      run_block(14, 4, 0, 1'b0, 1'b0);
      run_block($urandom_range(0, 15), 0, 0, 1'b0, 1'b0);
      run_block($urandom_range(0, 15), 3, 2, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         c = $urandom_range(1, 16);
         run_block($urandom_range(0, 15), c, 1, (c >= 2), 1'b0);
      end
      run_block($urandom_range(0, 15), 16, 0, 1'b0, 1'b0);
      run_block($urandom_range(0, 15), 1, 0, 1'b0, 1'b1);

      // Abort after the first of four words has been accepted.
      @(negedge clk);
      start = 1'b1; start_address = 4'($urandom_range(0, 15)); word_count = 5'd4; tx_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_abort_valid", 32'(tx_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_valid", 32'(tx_valid), 32'd0);
      chk("abort_data", 32'(tx_data), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rf_address", 32'(rf_address), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_abort_no_done", 32'(done), 32'd0);
      end
      run_block($urandom_range(0, 15), 5, 0, 1'b0, 1'b0);

`ifdef DATA_REGISTER_READER_PARITY_EN
      mem[8] = 16'h0007; mem[9] = 16'h0003;
      run_block(8, 2, 0, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
